spi_register_subunit: RTL
=========================

// Module: spi_register_subunit
// PURPOSE
// - SPI peripheral (subunit) that sits directly downstream of the SPI controller on SPI_SCLK/SPI_MOSI/SPI_CS and drives SPI_MISO.
// - Implements a register-file protocol: command byte, address byte, then data bytes with address auto-increment while CS is low.
// - All SPI inputs are oversampled in the clk domain. A parallel local port exposes the register file to on-chip logic.
// PARAMETERS
// - ADDR_WIDTH  4      register count = 2**ADDR_WIDTH, 8 bits each
// - CMD_WRITE   8'h0A  command byte for a register write burst
// - CMD_READ    8'h0B  command byte for a register read burst
// - DEVICE_ID   8'hAD  constant returned at address 0 when SPI_SUBUNIT_ID_EN is defined
// PORTS
// - clk         input   1           system clock, same domain as the SPI controller
// - rst         input   1           asynchronous, active-low reset
// - SPI_SCLK    input   1           serial clock from controller; mode 0 (idle low)
// - SPI_MOSI    input   1           serial data in, MSB first
// - SPI_CS      input   1           chip select, active low
// - SPI_MISO    output  1           serial data out, MSB first
// - reg_addr    input   ADDR_WIDTH  local read address
// - reg_rdata   output  8           registered read data for reg_addr, 1-cycle latency
// - wr_strobe   output  1           1-cycle pulse per committed SPI write
// - wr_addr     output  ADDR_WIDTH  address of the committed write, valid with wr_strobe
// - wr_data     output  8           data of the committed write, valid with wr_strobe
// - busy        output  1           synchronized CS is low
// - xfer_done   output  1           1-cycle pulse when synchronized CS rises
// BEHAVIOUR
// - Input sync: SCLK, MOSI and CS each pass through a 2-FF synchronizer. A third stage on SCLK/CS gives edge detects.
//   - Edge detection is 3 cycles after the pin changes.
//   - Requires an SCLK half-period of at least 4 clk cycles.
// - Reset (rst=0, async):
//   - SPI_MISO=0, reg_rdata=0, wr_strobe=0, wr_data=0, wr_addr=0, busy=0, xfer_done=0.
//   - All registers cleared to 0; state=IDLE; synchronizers cleared with CS=1 (deselected).
// - Bit engine:
//   - Detected SCLK rise: shift MOSI into an 8-bit rx shifter; 3-bit bit counter increments.
//   - Counter wrapping 7->0 marks byte complete.
//   - Detected SCLK fall: shift tx shifter and drive its MSB on SPI_MISO.
// - FSM states: IDLE, CMD, ADDR, WDATA, RDATA, IGNORE.
//   - IDLE -> CMD on detected CS fall; bit counter and shifters cleared.
//   - CMD, byte complete:
//     - rx==CMD_WRITE -> ADDR, write flag set.
//     - rx==CMD_READ -> ADDR, write flag clear.
//     - Any other byte -> IGNORE.
//   - ADDR, byte complete: ptr <= rx[ADDR_WIDTH-1:0] (upper bits discarded).
//     - Write flag set -> WDATA.
//     - Write flag clear -> RDATA; tx shifter loads regs[ptr]; ptr <= ptr+1.
//   - WDATA, byte complete: regs[ptr] <= rx; wr_strobe/wr_addr/wr_data pulse the next cycle; ptr <= ptr+1.
//   - RDATA, byte complete: tx loads regs[ptr], ptr <= ptr+1. The next SCLK fall presents the new MSB.
//   - Read data is sampled at load time; later writes via SPI are not reflected in an in-flight byte.
//   - IGNORE: all bytes discarded until CS rises; SPI_MISO held 0.
//   - Any state -> IDLE on detected CS rise; xfer_done pulses; SPI_MISO <= 0.
// - MISO timing:
//   - Read byte N MSB is driven at the SCLK fall ending the previous byte; it stays stable through the controller's sampling edge.
//   - MISO=0 during CMD and ADDR bytes and WDATA.
// - Boundaries:
//   - ptr wraps modulo 2**ADDR_WIDTH in both read and write bursts.
//   - CS rising mid-byte aborts: the partial byte is discarded and no write is committed. Bytes already completed stay committed.
//   - CMD/ADDR-only transactions (CS rise before data) have no register effect.
//   - rst asserted mid-transfer: immediate reset values; the transaction is lost.
//   - SCLK edges while CS is high are ignored.
//   - Local reg_addr read and SPI write to the same address in the same cycle: reg_rdata returns the old value; the new value appears the next cycle.
// CONFIGURATION
// - SPI_SUBUNIT_ID_EN defined: address 0 reads DEVICE_ID on both SPI and the local port.
//   - SPI writes to address 0 are dropped: no register update, no wr_strobe. ptr still increments.
// - Not defined: address 0 is an ordinary read/write register.
// TESTING
// - Write: CS low, send 0x0A,0x03,0x55, CS high -> one wr_strobe with wr_addr=3, wr_data=0x55; reg_addr=3 gives reg_rdata=0x55; xfer_done pulses once.
// - Read burst: after writing 0x11,0x22 to addresses 5,6, send 0x0B,0x05,0x00,0x00 -> controller receives 0x11 then 0x22; no wr_strobe.
// - Wrap: ADDR_WIDTH=4, send 0x0A,0x0F,0xAA,0xBB -> regs[15]=0xAA, regs[0]=0xBB (ID macro undefined).
// - Abort: send 0x0A,0x02, then 4 bits of 0xF0, then CS high -> regs[2] unchanged, no wr_strobe; the next transaction works normally.
// - Bad command: send 0x5A,0x01,0x77 -> no register change, MISO=0 throughout, xfer_done pulses.
// - With SPI_SUBUNIT_ID_EN: send 0x0B,0x00,0x00 -> 0xAD received. Then 0x0A,0x00,0x12 -> no wr_strobe, reg_rdata at address 0 stays 0xAD.

Source files
------------

// File: rtl/spi_register_subunit.sv
// SPI register-file peripheral: command, address, then auto-incrementing data bytes, SPI inputs oversampled in clk.
// Optional feature macro SPI_SUBUNIT_ID_EN: address 0 reads DEVICE_ID and ignores SPI writes.
module spi_register_subunit #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter logic [7:0]  CMD_WRITE  = 8'h0A,
  parameter logic [7:0]  CMD_READ   = 8'h0B,
  parameter logic [7:0]  DEVICE_ID  = 8'hAD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  SPI_SCLK,
  input  logic                  SPI_MOSI,
  input  logic                  SPI_CS,
  output logic                  SPI_MISO,
  input  logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [7:0]            reg_rdata,
  output logic                  wr_strobe,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [7:0]            wr_data,
  output logic                  busy,
  output logic                  xfer_done
);

  localparam int unsigned NREGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
`ifdef SPI_SUBUNIT_ID_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif

  typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_ADDR, ST_WDATA, ST_RDATA, ST_IGNORE} state_t;

  state_t                  state_r;
  logic [2:0]              sclk_sync_r;
  logic [2:0]              cs_sync_r;
  logic [1:0]              mosi_sync_r;
  logic [2:0]              bit_cnt_r;
  logic [7:0]              rx_r;
  logic [7:0]              tx_r;
  logic                    write_r;
  logic [ADDR_WIDTH-1:0]   ptr_r;
  logic [7:0]              regs_r [NREGS];
  logic                    miso_r;
  logic [7:0]              reg_rdata_r;
  logic                    wr_strobe_r;
  logic [ADDR_WIDTH-1:0]   wr_addr_r;
  logic [7:0]              wr_data_r;
  logic                    busy_r;
  logic                    xfer_done_r;

  logic                    sclk_rise_s;
  logic                    sclk_fall_s;
  logic                    cs_rise_s;
  logic                    cs_fall_s;
  logic                    byte_done_s;
  logic [7:0]              rx_next_s;

  // Register-file view with the optional fixed ID at address 0.
  function automatic logic [7:0] read_reg(input logic [ADDR_WIDTH-1:0] a);
    if (ID_EN && (a == '0)) begin
      return DEVICE_ID;
    end else begin
      return regs_r[a];
    end
  endfunction

  // Edge detects on the synchronized pins and the byte-complete condition.
  always_comb begin
    sclk_rise_s = sclk_sync_r[1] & ~sclk_sync_r[2];
    sclk_fall_s = ~sclk_sync_r[1] & sclk_sync_r[2];
    cs_rise_s   = cs_sync_r[1] & ~cs_sync_r[2];
    cs_fall_s   = ~cs_sync_r[1] & cs_sync_r[2];
    rx_next_s   = {rx_r[6:0], mosi_sync_r[1]};
    byte_done_s = sclk_rise_s && (bit_cnt_r == 3'd7);
  end

  // Input synchronizers; CS resets to deselected.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync_r <= 3'b000;
      cs_sync_r   <= 3'b111;
      mosi_sync_r <= 2'b00;
    end else begin
      sclk_sync_r <= {sclk_sync_r[1:0], SPI_SCLK};
      cs_sync_r   <= {cs_sync_r[1:0], SPI_CS};
      mosi_sync_r <= {mosi_sync_r[0], SPI_MOSI};
    end
  end

  // Protocol FSM, bit engine, register file and write-commit outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      bit_cnt_r   <= 3'd0;
      rx_r        <= 8'h00;
      tx_r        <= 8'h00;
      write_r     <= 1'b0;
      ptr_r       <= '0;
      miso_r      <= 1'b0;
      reg_rdata_r <= 8'h00;
      wr_strobe_r <= 1'b0;
      wr_addr_r   <= '0;
      wr_data_r   <= 8'h00;
      busy_r      <= 1'b0;
      xfer_done_r <= 1'b0;
      for (int i = 0; i < NREGS; i++) begin
        regs_r[i] <= 8'h00;
      end
    end else begin
      wr_strobe_r <= 1'b0;
      xfer_done_r <= 1'b0;
      busy_r      <= ~cs_sync_r[1];
      reg_rdata_r <= read_reg(reg_addr);
      if ((state_r != ST_IDLE) && cs_rise_s) begin
        // Deselect aborts whatever partial byte is in flight.
        state_r     <= ST_IDLE;
        xfer_done_r <= 1'b1;
        miso_r      <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            if (cs_fall_s) begin
              state_r   <= ST_CMD;
              bit_cnt_r <= 3'd0;
              rx_r      <= 8'h00;
              tx_r      <= 8'h00;
              miso_r    <= 1'b0;
            end
          end
          default: begin
            if (sclk_rise_s) begin
              rx_r      <= rx_next_s;
              bit_cnt_r <= bit_cnt_r + 3'd1;
              if (byte_done_s) begin
                case (state_r)
                  ST_CMD: begin
                    if (rx_next_s == CMD_WRITE) begin
                      state_r <= ST_ADDR;
                      write_r <= 1'b1;
                    end else if (rx_next_s == CMD_READ) begin
                      state_r <= ST_ADDR;
                      write_r <= 1'b0;
                    end else begin
                      state_r <= ST_IGNORE;
                    end
                  end
                  ST_ADDR: begin
                    if (write_r) begin
                      state_r <= ST_WDATA;
                      ptr_r   <= rx_next_s[ADDR_WIDTH-1:0];
                    end else begin
                      state_r <= ST_RDATA;
                      tx_r    <= read_reg(rx_next_s[ADDR_WIDTH-1:0]);
                      ptr_r   <= rx_next_s[ADDR_WIDTH-1:0] + PTR_ONE;
                    end
                  end
                  ST_WDATA: begin
                    if (!(ID_EN && (ptr_r == '0))) begin
                      regs_r[ptr_r] <= rx_next_s;
                      wr_strobe_r   <= 1'b1;
                      wr_addr_r     <= ptr_r;
                      wr_data_r     <= rx_next_s;
                    end
                    ptr_r <= ptr_r + PTR_ONE;
                  end
                  ST_RDATA: begin
                    tx_r  <= read_reg(ptr_r);
                    ptr_r <= ptr_r + PTR_ONE;
                  end
                  default: begin
                    state_r <= ST_IGNORE;
                  end
                endcase
              end
            end else if (sclk_fall_s) begin
              miso_r <= (state_r == ST_IGNORE) ? 1'b0 : tx_r[7];
              tx_r   <= {tx_r[6:0], 1'b0};
            end
          end
        endcase
      end
    end
  end

  assign SPI_MISO  = miso_r;
  assign reg_rdata = reg_rdata_r;
  assign wr_strobe = wr_strobe_r;
  assign wr_addr   = wr_addr_r;
  assign wr_data   = wr_data_r;
  assign busy      = busy_r;
  assign xfer_done = xfer_done_r;

endmodule
